// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage-0 PC generator.
//
// Holds the request bundle layout, the slot/offset geometry for the
// default fetch configuration and the PC generator state encoding.
// The PC generator itself derives its geometry from its own parameters,
// so these constants describe the default build only.
package fetch_pkg;

    localparam int unsigned XLEN_DEF        = 64;
    localparam int unsigned FETCH_BYTES_DEF = 16;
    localparam int unsigned SLOT_BYTES_DEF  = 4;
    localparam int unsigned EPOCH_W_DEF     = 3;

    localparam int unsigned SLOT_NUM = FETCH_BYTES_DEF / SLOT_BYTES_DEF;
    // PC bits that select the starting slot inside a fetch block.
    localparam int unsigned OFF_LSB  = $clog2(SLOT_BYTES_DEF);
    localparam int unsigned OFF_MSB  = $clog2(FETCH_BYTES_DEF) - 1;

    typedef struct packed {
        logic [XLEN_DEF-1:0]    pc;
        logic [SLOT_NUM-1:0]    mask;
        logic [EPOCH_W_DEF-1:0] epoch;
    } fetch_req_t;

    typedef enum logic {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/fetch_pc_gen_redir_arb.sv
// Fixed-priority redirect arbiter.
//
// Picks the highest-indexed asserted redirect source (the oldest pipeline
// stage has the highest index and therefore wins) and forwards its target.
//
// Ports:
//   i_valid  per-source redirect strobes
//   i_pc     per-source targets, source k at [k*XLEN +: XLEN]
//   o_valid  any source asserted
//   o_idx    index of the winning source (0 when none)
//   o_pc     target of the winning source (0 when none)
module redir_arb #(
    parameter int unsigned N     = 4,
    parameter int unsigned XLEN  = 64,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]      i_valid,
    input  logic [N*XLEN-1:0] i_pc,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_idx,
    output logic [XLEN-1:0]   o_pc
);

    always_comb begin
        o_valid = |i_valid;
        o_idx   = '0;
        o_pc    = '0;
        // Ascending scan: a later (higher) asserted index overrides earlier ones.
        for (int k = 0; k < int'(N); k++) begin
            if (i_valid[k]) begin
                o_idx = IDX_W'(k);
                o_pc  = i_pc[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch stage-0 PC generator.
//
// Produces fetch-block requests to the I-cache over a valid/ready
// handshake, follows prioritised redirects from later pipeline stages,
// tags each request with an epoch and a slot-valid mask, and limits the
// number of accepted-but-unretired requests with a credit counter.
//
// Ports:
//   i_clk, i_rstn     clock, asynchronous active-low reset
//   i_stall           freeze: no request issued (redirects still taken)
//   i_redir_valid     per-source redirect strobes (higher index wins)
//   i_redir_pc        per-source targets, source k at [k*XLEN +: XLEN]
//   i_fetch_ready     I-cache accepts the current request
//   i_fetch_retire    one earlier-accepted request has completed
//   o_fetch_valid     request valid
//   o_fetch_pc        slot-aligned request PC
//   o_fetch_mask      valid slots within the fetch block
//   o_fetch_epoch     epoch tag of the request
//   o_redir_src       index of the last accepted redirect source
//   o_credits         free request credits
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = 64,
    parameter int unsigned     NUM_REDIR       = 4,
    parameter int unsigned     FETCH_BYTES     = 16,
    parameter int unsigned     SLOT_BYTES      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 4,
    parameter int unsigned     EPOCH_W         = 3,
    parameter logic [XLEN-1:0] RESET_PC        = 'h8000_0000,
    localparam int unsigned    SRC_W  = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1,
    localparam int unsigned    CRED_W = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned    SLOTS  = FETCH_BYTES / SLOT_BYTES
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic                      i_stall,
    input  logic [NUM_REDIR-1:0]      i_redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] i_redir_pc,
    input  logic                      i_fetch_ready,
    input  logic                      i_fetch_retire,
    output logic                      o_fetch_valid,
    output logic [XLEN-1:0]           o_fetch_pc,
    output logic [SLOTS-1:0]          o_fetch_mask,
    output logic [EPOCH_W-1:0]        o_fetch_epoch,
    output logic [SRC_W-1:0]          o_redir_src,
    output logic [CRED_W-1:0]         o_credits
);

    localparam logic [XLEN-1:0]   BLOCK_MASK = XLEN'(FETCH_BYTES - 1);
    localparam logic [XLEN-1:0]   SLOT_MASK  = XLEN'(SLOT_BYTES - 1);
    localparam logic [CRED_W-1:0] CRED_MAX   = CRED_W'(MAX_OUTSTANDING);

    fsm_state_t         r_state;
    fsm_state_t         w_state_nxt;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    w_pc_nxt;
    logic [EPOCH_W-1:0] r_epoch;
    logic [SRC_W-1:0]   r_redir_src;
    logic [CRED_W-1:0]  r_credits;
    logic [CRED_W-1:0]  w_credits_nxt;

    logic               w_redir_valid;
    logic [SRC_W-1:0]   w_redir_idx;
    logic [XLEN-1:0]    w_redir_pc;
    logic               w_valid;
    logic               w_fire;
    logic [SLOTS-1:0]   w_mask;

    redir_arb #(
        .N     (NUM_REDIR),
        .XLEN  (XLEN),
        .IDX_W (SRC_W)
    ) u_redir_arb (
        .i_valid (i_redir_valid),
        .i_pc    (i_redir_pc),
        .o_valid (w_redir_valid),
        .o_idx   (w_redir_idx),
        .o_pc    (w_redir_pc)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and request valid. A redirect withdraws the request in
    // the same cycle so a stale-PC request can never be accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_valid = !i_stall && (r_credits != '0) && !w_redir_valid;
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign w_fire = w_valid && i_fetch_ready;

    // Next PC: redirect target is slot-aligned; a sequential step moves to
    // the start of the following fetch block. Wrap at 2^XLEN is silent.
    always_comb begin
        w_pc_nxt = r_pc;
        if (w_redir_valid) begin
            w_pc_nxt = w_redir_pc & ~SLOT_MASK;
        end else if (w_fire) begin
            w_pc_nxt = (r_pc & ~BLOCK_MASK) + XLEN'(FETCH_BYTES);
        end
    end

    // Credits: fire consumes, retire refunds, both together cancel.
    // A retire with all credits free is a protocol error; hold at the max.
    always_comb begin
        w_credits_nxt = r_credits;
        if (w_fire && !i_fetch_retire) begin
            w_credits_nxt = r_credits - CRED_W'(1);
        end else if (!w_fire && i_fetch_retire && (r_credits != CRED_MAX)) begin
            w_credits_nxt = r_credits + CRED_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pc        <= RESET_PC;
            r_epoch     <= '0;
            r_redir_src <= '0;
            r_credits   <= CRED_MAX;
        end else begin
            r_pc      <= w_pc_nxt;
            r_credits <= w_credits_nxt;
            if (w_redir_valid) begin
                r_epoch     <= r_epoch + EPOCH_W'(1);
                r_redir_src <= w_redir_idx;
            end
        end
    end

    // Slot mask: slots before the entry slot of the block are invalid.
    if (SLOTS > 1) begin : g_mask
        localparam int unsigned L_OFF_LSB = $clog2(SLOT_BYTES);
        localparam int unsigned L_OFF_MSB = $clog2(FETCH_BYTES) - 1;
        logic [L_OFF_MSB-L_OFF_LSB:0] w_off;

        assign w_off = r_pc[L_OFF_MSB:L_OFF_LSB];

        always_comb begin
            w_mask = '0;
            for (int i = 0; i < int'(SLOTS); i++) begin
                w_mask[i] = (i >= int'(w_off));
            end
        end
    end else begin : g_mask_single
        assign w_mask = 1'b1;
    end

    assign o_fetch_valid = w_valid;
    assign o_fetch_pc    = r_pc;
    assign o_fetch_mask  = w_mask;
    assign o_fetch_epoch = r_epoch;
    assign o_redir_src   = r_redir_src;
    assign o_credits     = r_credits;

endmodule
